// File: rtl/mvm_axis_loader.sv
// mvm_axis_loader: feeder for the rtl_mvm tile.
// Takes load commands plus a 64-bit beat stream. Packs every eight beats into
// one 512-bit word and emits it as a single-beat AXI-Stream packet. tuser is
// {mask, op, addr}.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   s_cmd_*                   command handshake: op, start addr, mask, word count
//   s_data_valid/ready, s_data  64-bit beat stream
//   m_axis_*                  packed output word (tdata/tuser/tlast)
//   busy                      a command is in progress or an output word is pending
//
// Build option: define LOADER_ADDR_AUTOINC_EN to make op 11 advance the RF
// address by one per emitted word, wrapping at the top. If it is undefined,
// every word carries the command address.
module mvm_axis_loader #(
  parameter int DATAW   = 512,
  parameter int INW     = 64,
  parameter int RFADDRW = 9,
  parameter int MASKW   = 64,
  parameter int USERW   = 75,
  parameter int COUNTW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_cmd_valid,
  output logic               s_cmd_ready,
  input  logic [1:0]         s_cmd_op,
  input  logic [RFADDRW-1:0] s_cmd_addr,
  input  logic [MASKW-1:0]   s_cmd_mask,
  input  logic [COUNTW-1:0]  s_cmd_count,
  input  logic               s_data_valid,
  output logic               s_data_ready,
  input  logic [INW-1:0]     s_data,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [DATAW-1:0]   m_axis_tdata,
  output logic [USERW-1:0]   m_axis_tuser,
  output logic               m_axis_tlast,
  output logic               busy
);

  localparam int BEATS = DATAW / INW;
  localparam int BEATW = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_t;

  state_t             state, state_nxt;
  logic [1:0]         op_q;
  logic [RFADDRW-1:0] addr_q;
  logic [MASKW-1:0]   mask_q;
  logic [COUNTW-1:0]  remain_q;   // words not yet moved to the output register
  logic [BEATW-1:0]   beat_q;
  logic               asm_full;
  logic [DATAW-1:0]   asm_q;
  logic               out_valid;
  logic [DATAW-1:0]   out_data;
  logic [USERW-1:0]   out_user;

  logic cmd_fire, beat_fire, xfer, drain, out_free;
  logic [USERW-1:0] user_word;

  always_comb begin
    state_nxt    = state;
    s_cmd_ready  = 1'b0;
    s_data_ready = 1'b0;
    xfer         = 1'b0;
    drain        = out_valid & m_axis_tready;
    out_free     = ~out_valid | m_axis_tready;
    case (state)
      IDLE: begin
        s_cmd_ready = ~rst;
        if (s_cmd_valid && !rst && s_cmd_count != '0)
          state_nxt = PACK;
      end
      PACK: begin
        xfer = asm_full & out_free;
        // A full buffer that is moving out this cycle frees slot 0 for the
        // next word's first beat. This does not apply once the final word
        // of the command has been assembled.
        s_data_ready = ~rst & (~asm_full | (out_free & (remain_q > COUNTW'(1))));
        if (xfer && remain_q == COUNTW'(1))
          state_nxt = FLUSH;
      end
      FLUSH: begin
        if (out_free)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_fire  = s_cmd_valid & s_cmd_ready;
  assign beat_fire = s_data_valid & s_data_ready;
  assign user_word = (op_q == 2'b11) ? {mask_q, op_q, addr_q}
                                     : {MASKW'(0), op_q, RFADDRW'(0)};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      remain_q  <= '0;
      beat_q    <= '0;
      asm_full  <= 1'b0;
      asm_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_user  <= '0;
    end else begin
      if (cmd_fire) begin
        op_q     <= s_cmd_op;
        addr_q   <= s_cmd_addr;
        mask_q   <= s_cmd_mask;
        remain_q <= s_cmd_count;
        beat_q   <= '0;
        asm_full <= 1'b0;
      end
      if (xfer) begin
        asm_full  <= 1'b0;
        out_valid <= 1'b1;
        out_data  <= asm_q;
        out_user  <= user_word;
        remain_q  <= remain_q - 1'b1;
`ifdef LOADER_ADDR_AUTOINC_EN
        if (op_q == 2'b11)
          addr_q <= addr_q + 1'b1;
`endif
      end else if (drain) begin
        out_valid <= 1'b0;
        out_data  <= '0;
        out_user  <= '0;
      end
      // When the buffer fills, beat_q is back at 0. A beat accepted during a
      // transfer is therefore always beat 0 of the next word. It never
      // conflicts with clearing asm_full above.
      if (beat_fire) begin
        asm_q[beat_q*INW +: INW] <= s_data;
        if (beat_q == BEATW'(BEATS-1)) begin
          beat_q   <= '0;
          asm_full <= 1'b1;
        end else begin
          beat_q <= beat_q + 1'b1;
        end
      end
    end
  end

  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_data;
  assign m_axis_tuser  = out_user;
  assign m_axis_tlast  = out_valid;
  assign busy          = (state != IDLE) | out_valid;

endmodule

// File: tb/tb_mvm_axis_loader.sv
`timescale 1ns/1ps
module tb_mvm_axis_loader;
  localparam int DATAW = 512, INW = 64, RFADDRW = 9, MASKW = 64, USERW = 75, COUNTW = 10;

  logic               clk = 1'b0, rst = 1'b1;
  logic               s_cmd_valid = 1'b0, s_cmd_ready;
  logic [1:0]         s_cmd_op = '0;
  logic [RFADDRW-1:0] s_cmd_addr = '0;
  logic [MASKW-1:0]   s_cmd_mask = '0;
  logic [COUNTW-1:0]  s_cmd_count = '0;
  logic               s_data_valid = 1'b0, s_data_ready;
  logic [INW-1:0]     s_data = '0;
  logic               m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast, busy;
  logic [DATAW-1:0]   m_axis_tdata;
  logic [USERW-1:0]   m_axis_tuser;

  always #5 clk = ~clk;

  mvm_axis_loader #(.DATAW(DATAW), .INW(INW), .RFADDRW(RFADDRW), .MASKW(MASKW),
                    .USERW(USERW), .COUNTW(COUNTW)) dut (
    .clk(clk), .rst(rst),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_op(s_cmd_op),
    .s_cmd_addr(s_cmd_addr), .s_cmd_mask(s_cmd_mask), .s_cmd_count(s_cmd_count),
    .s_data_valid(s_data_valid), .s_data_ready(s_data_ready), .s_data(s_data),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .busy(busy));

  int ncomp = 0, nfail = 0, cyc = 0;
  int ready_mode = 0;   // 0: tready low, 1: tready high, 2: random
  bit gaps = 0, seen_valid = 0;
  logic             prev_stall = 1'b0;
  logic [DATAW-1:0] prev_data;
  logic [USERW-1:0] prev_user;
  logic [DATAW-1:0] rx_data[$], ex_data[$];
  logic [USERW-1:0] rx_user[$], ex_user[$];
  int               rx_cyc[$];

  task automatic check(input string tag, input logic [DATAW-1:0] obs, input logic [DATAW-1:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: records handshakes and checks that a stalled word is held.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_axis_tvalid, 1);
        check("hold_data", m_axis_tdata, prev_data);
        check("hold_user", m_axis_tuser, prev_user);
      end
      if (m_axis_tvalid) seen_valid = 1;
      if (m_axis_tvalid && m_axis_tready) begin
        rx_data.push_back(m_axis_tdata);
        rx_user.push_back(m_axis_tuser);
        rx_cyc.push_back(cyc);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_user  = m_axis_tuser;
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [8:0] addr, input logic [63:0] mask, input int count);
    bit got = 0;
    s_cmd_valid = 1; s_cmd_op = op; s_cmd_addr = addr; s_cmd_mask = mask; s_cmd_count = 10'(count);
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk); got = s_cmd_ready;
      @(posedge clk); #1;
    end
    s_cmd_valid = 0;
    if (!got) check("cmd_timeout", got, 1);
  endtask

  task automatic send_beat(input logic [63:0] b);
    bit got = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    s_data_valid = 1; s_data = b;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk); got = s_data_ready;
      @(posedge clk); #1;
    end
    s_data_valid = 0;
    if (!got) check("beat_timeout", got, 1);
  endtask

  // Reference model: each word is the 8 beats concatenated little-end first.
  // tuser carries the address/mask only for RF writes.
  task automatic run_cmd(input logic [1:0] op, input logic [8:0] addr, input logic [63:0] mask,
                         input int count, input bit seq);
    logic [63:0] b;
    logic [511:0] w;
    logic [8:0] a;
    send_cmd(op, addr, mask, count);
    for (int n = 0; n < count; n++) begin
      w = '0;
      for (int k = 0; k < 8; k++) begin
        b = seq ? 64'(n * 8 + k + 1) : {$urandom, $urandom};
        w[k*64 +: 64] = b;
        send_beat(b);
      end
`ifdef LOADER_ADDR_AUTOINC_EN
      a = addr + 9'(n);
`else
      a = addr;
`endif
      ex_data.push_back(w);
      ex_user.push_back(op == 2'b11 ? {mask, 2'b11, a} : {64'h0, op, 9'h0});
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      done = !busy && !m_axis_tvalid;
    end
    if (!done) check("idle_timeout", done, 1);
    @(posedge clk); #1;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_nwords"}, rx_data.size(), ex_data.size());
    for (int i = 0; i < rx_data.size() && i < ex_data.size(); i++) begin
      check({tag, "_data"}, rx_data[i], ex_data[i]);
      check({tag, "_user"}, rx_user[i], ex_user[i]);
    end
    rx_data.delete(); rx_user.delete(); rx_cyc.delete();
    ex_data.delete(); ex_user.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, s_cmd_ready, 0);
    check({tag, "_data_ready"}, s_data_ready, 0);
    check({tag, "_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_tdata"}, m_axis_tdata, 0);
    check({tag, "_tuser"}, m_axis_tuser, 0);
    check({tag, "_tlast"}, m_axis_tlast, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] exp_a;
    // Reset
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("rst_cmd_ready_after", s_cmd_ready, 1);
    @(posedge clk); #1;

    // Single RF write word. Check latency and field placement with tready held low.
    ready_mode = 0;
    run_cmd(2'b11, 9'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1);
    @(negedge clk);
    check("t1_lat_pre", m_axis_tvalid, 0);
    @(negedge clk);
    check("t1_tvalid", m_axis_tvalid, 1);
    check("t1_beat0", m_axis_tdata[63:0], 64'h1);
    check("t1_beat7", m_axis_tdata[511:448], 64'h8);
    check("t1_tuser", m_axis_tuser, {64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 9'h1});
    check("t1_tlast", m_axis_tlast, 1);
    check("t1_busy", busy, 1);
    ready_mode = 1;
    wait_idle();
    compare_all("t1");

    // Backpressure: two input-vector words with tready low for 20 cycles.
    ready_mode = 0;
    run_cmd(2'b10, 9'h5A, {$urandom, $urandom}, 2, 0);
    @(negedge clk);
    check("stall_data_ready", s_data_ready, 0);
    check("stall_tvalid", m_axis_tvalid, 1);
    check("stall_word0", m_axis_tdata, ex_data[0]);
    check("stall_tuser", m_axis_tuser, 75'h2 << 9);
    repeat (19) @(negedge clk);
    @(posedge clk); #1;
    ready_mode = 1;
    wait_idle();
    compare_all("stall");

    // Address wrap and throughput spacing.
    run_cmd(2'b11, 9'd511, {$urandom, $urandom}, 3, 0);
    wait_idle();
    check("wrap_nwords", rx_user.size(), 3);
    for (int i = 0; i < rx_user.size() && i < 3; i++) begin
`ifdef LOADER_ADDR_AUTOINC_EN
      exp_a = 9'd511 + 9'(i);
`else
      exp_a = 9'd511;
`endif
      check("wrap_addr", rx_user[i][8:0], exp_a);
      if (i > 0) check("wrap_spacing", rx_cyc[i] - rx_cyc[i-1], 8);
    end
    compare_all("wrap");

    // Zero-count command
    seen_valid = 0;
    send_cmd(2'b11, 9'h10, 64'hFF, 0);
    @(negedge clk);
    check("zero_cmd_ready", s_cmd_ready, 1);
    check("zero_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("zero_no_valid", seen_valid, 0);
    check("zero_busy_late", busy, 0);
    @(posedge clk); #1;
    compare_all("zero");

    // Reset in the middle of a word
    send_cmd(2'b11, 9'h7, 64'h1234, 1);
    for (int k = 0; k < 5; k++) send_beat({$urandom, $urandom});
    rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 0;
    ex_data.delete(); ex_user.delete();
    rx_data.delete(); rx_user.delete(); rx_cyc.delete();
    run_cmd(2'b11, 9'h33, 64'hA5A5_0000_FFFF_1234, 1, 1);
    wait_idle();
    compare_all("midrst");

    // Back-to-back reduction-vector then instruction commands
    run_cmd(2'b01, 9'($urandom), {$urandom, $urandom}, 1, 0);
    run_cmd(2'b00, 9'($urandom), {$urandom, $urandom}, 1, 0);
    wait_idle();
    check("b2b_nwords", rx_user.size(), 2);
    if (rx_user.size() == 2) begin
      check("b2b_op0", rx_user[0][10:9], 2'b01);
      check("b2b_op1", rx_user[1][10:9], 2'b00);
    end
    compare_all("b2b");

    // Randomized commands, random beat gaps and random tready
    gaps = 1;
    ready_mode = 2;
    for (int c = 0; c < 8; c++)
      run_cmd(2'($urandom), 9'($urandom), {$urandom, $urandom}, $urandom_range(0, 3), 0);
    ready_mode = 1;
    wait_idle();
    compare_all("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
